// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter, one parallel word per strobe serialised LSB first on tx_o
module uart_tx #(
   parameter int UART_BAUD_RATE             = 19200,
   parameter int UART_DATA_LENGTH           = 8,
   parameter int CLK_FREQ                   = 10000000,
   parameter int TX_COUNTER_BITWIDTH        = 3,
   parameter int BAUD_COUNTS_PER_BIT        = 521,
   parameter int BAUD_RATE_COUNTER_BITWIDTH = 10
) (
   input  logic                        clk_i,
   input  logic                        reset_i,
   input  logic [UART_DATA_LENGTH-1:0] data_i,
   input  logic                        data_valid_strb_i,
   output logic                        tx_o,
   output logic                        busy_o,
   output logic                        done_strb_o
);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   localparam logic [BAUD_RATE_COUNTER_BITWIDTH-1:0] LAST_CNT =
      BAUD_RATE_COUNTER_BITWIDTH'(BAUD_COUNTS_PER_BIT - 1);
   localparam logic [TX_COUNTER_BITWIDTH-1:0] LAST_BIT = TX_COUNTER_BITWIDTH'(UART_DATA_LENGTH - 1);
   state_t                                state;
   logic [BAUD_RATE_COUNTER_BITWIDTH-1:0] cnt;
   logic [TX_COUNTER_BITWIDTH-1:0]        idx;
   logic [UART_DATA_LENGTH-1:0]           shift;
   logic                                  bit_end;
   // Baud rate and clock frequency are documentation only; reject settings the counters cannot hold.
   if (TX_COUNTER_BITWIDTH < $clog2(UART_DATA_LENGTH) ||
       BAUD_RATE_COUNTER_BITWIDTH < $clog2(BAUD_COUNTS_PER_BIT) ||
       CLK_FREQ < UART_BAUD_RATE || UART_DATA_LENGTH < 2) begin : g_bad_params
      $error("uart_tx: inconsistent parameters");
   end
   assign bit_end = cnt == LAST_CNT;
   assign busy_o  = state != IDLE;
   // Frame sequencer: line level, shift register, bit index and done pulse all registered here.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state       <= IDLE;
         cnt         <= '0;
         idx         <= '0;
         shift       <= '0;
         tx_o        <= 1'b1;
         done_strb_o <= 1'b0;
      end else begin
         done_strb_o <= 1'b0;
         cnt         <= (state == IDLE || bit_end) ? '0 : cnt + 1'b1;
         case (state)
            IDLE:
               if (data_valid_strb_i) begin
                  shift <= data_i;
                  tx_o  <= 1'b0;
                  state <= START;
               end
            START:
               if (bit_end) begin
                  tx_o  <= shift[0];
                  idx   <= '0;
                  state <= DATA;
               end
            DATA:
               if (bit_end) begin
                  shift <= {1'b0, shift[UART_DATA_LENGTH-1:1]};
                  idx   <= idx + 1'b1;
                  tx_o  <= (idx == LAST_BIT) ? 1'b1 : shift[1];
                  state <= (idx == LAST_BIT) ? STOP : DATA;
               end
            STOP:
               if (bit_end) begin
                  state       <= IDLE;
                  done_strb_o <= 1'b1;
               end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx with a bit-accurate serial line monitor
module tb_uart_tx;
   localparam int N     = 52;
   localparam int FRAME = 10 * N;
   logic       clk = 1'b0;
   logic       reset_i = 1'b0;
   logic       stb = 1'b0;
   logic [7:0] data = 8'h00;
   logic       tx, busy, done;
   int         n_chk = 0, n_pass = 0;
   int         rx_cnt = 0, done_cnt = 0, busy_cnt = 0, cyc = 0;
   int         done_cyc = -100, gap = -1;
   int         d0, b0, r0;
   logic [9:0] last_line = '0;
   logic [7:0] sb[$];

   uart_tx #(.BAUD_COUNTS_PER_BIT(N)) dut (
      .clk_i(clk), .reset_i(reset_i), .data_i(data), .data_valid_strb_i(stb),
      .tx_o(tx), .busy_o(busy), .done_strb_o(done)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic send(input logic [7:0] d, input bit accept);
      @(negedge clk);
      data = d;
      stb  = 1'b1;
      if (accept) sb.push_back(d);
      @(negedge clk);
      stb  = 1'b0;
      data = 8'($urandom);
   endtask

   task automatic wait_idle(input string tag);
      int k = 0;
      while (busy !== 1'b0 && k < 2 * FRAME) begin
         @(negedge clk);
         k++;
      end
      chk(tag, busy, 0);
   endtask

   task automatic wait_done(input string tag);
      int k = 0;
      while (done !== 1'b1 && k < 2 * FRAME) begin
         @(negedge clk);
         k++;
      end
      chk(tag, done, 1);
   endtask

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (done === 1'b1) done_cnt <= done_cnt + 1;
      if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
   end

   // Serial monitor: captures every frame cycle by cycle and checks it against the scoreboard.
   initial forever begin
      @(posedge clk);
      #1;
      if (reset_i && tx === 1'b0) begin
         bit         ok, abort;
         logic [9:0] line;
         ok    = 1'b1;
         abort = 1'b0;
         line  = '0;
         gap   = cyc - done_cyc;
         for (int s = 0; s < 10 && !abort; s++)
            for (int c = 0; c < N && !abort; c++) begin
               if (s != 0 || c != 0) begin
                  @(posedge clk);
                  #1;
               end
               if (!reset_i) abort = 1'b1;
               else if (c == 0) line[s] = tx;
               else if (tx !== line[s] || busy !== 1'b1 || done !== 1'b0) ok = 1'b0;
            end
         if (!abort) begin
            @(posedge clk);
            #1;
            done_cyc = cyc;
            chk("done_after_stop", done, 1);
            chk("busy_after_stop", busy, 0);
            chk("frame_shape", ok, 1);
            chk("start_stop", {line[9], line[0]}, 2'b10);
            chk("frame_expected", sb.size() > 0, 1);
            if (sb.size() > 0) chk("frame_data", line[8:1], sb.pop_front());
            last_line = line;
            rx_cnt++;
         end
      end
   end

   initial begin
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("rst_outputs", {tx, busy, done}, 3'b100);
      end
      reset_i = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_after_release", {tx, busy, done}, 3'b100);

      d0 = done_cnt;
      b0 = busy_cnt;
      send(8'hCC, 1'b1);
      wait_idle("t2_idle");
      repeat (2) @(negedge clk);
      chk("t2_line", last_line, {1'b1, 8'hCC, 1'b0});
      chk("t2_busy_cycles", busy_cnt - b0, FRAME);
      chk("t2_done_pulses", done_cnt - d0, 1);

      r0 = rx_cnt;
      send(8'h00, 1'b1);
      for (int i = 1; i < 16; i++) begin
         wait_done("lb_done");
         data = 8'(i);
         stb  = 1'b1;
         sb.push_back(8'(i));
         @(negedge clk);
         stb = 1'b0;
         @(negedge clk);
         chk("lb_gap", gap, 1);
      end
      wait_idle("lb_idle");
      repeat (2) @(negedge clk);
      chk("lb_frames", rx_cnt - r0, 16);
      chk("lb_sb_empty", sb.size(), 0);

      send(8'h5A, 1'b1);
      wait_done("t6_done");
      data = 8'hC3;
      stb  = 1'b1;
      sb.push_back(8'hC3);
      @(negedge clk);
      stb = 1'b0;
      chk("t6_start_on_done_edge", {tx, busy}, 2'b01);
      @(negedge clk);
      chk("t6_gap", gap, 1);
      wait_idle("t6_idle");
      repeat (2) @(negedge clk);
      chk("t6_line", last_line, {1'b1, 8'hC3, 1'b0});

      r0 = rx_cnt;
      b0 = busy_cnt;
      send(8'hA5, 1'b1);
      repeat (2 * N) @(negedge clk);
      send(8'h3C, 1'b0);
      wait_idle("t4_idle");
      repeat (2 * N) @(negedge clk);
      chk("t4_frames", rx_cnt - r0, 1);
      chk("t4_busy_cycles", busy_cnt - b0, FRAME);
      chk("t4_line", last_line, {1'b1, 8'hA5, 1'b0});
      chk("t4_line_idle", tx, 1);

      r0 = rx_cnt;
      send(8'hFF, 1'b1);
      repeat (4 * N + N / 2) @(negedge clk);
      #2 reset_i = 1'b0;
      #1 chk("t5_async_reset", {tx, busy}, 2'b10);
      d0 = done_cnt;
      sb.delete();
      repeat (5) @(negedge clk);
      chk("t5_held", {tx, busy, done}, 3'b100);
      reset_i = 1'b1;
      repeat (2 * N) @(negedge clk);
      chk("t5_no_done", done_cnt - d0, 0);
      chk("t5_no_frame", rx_cnt - r0, 0);
      send(8'h81, 1'b1);
      wait_idle("t5_idle");
      repeat (2) @(negedge clk);
      chk("t5_next_frame", last_line, {1'b1, 8'h81, 1'b0});
      chk("t5_sb_empty", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
